// File: rtl/aspiradora_ctrl.sv
// Robot vacuum sequencer: power/clean/evade/return/charge FSM with a battery model.
// Battery drains while moving and refills on the dock through a shared cycle prescaler.
module aspiradora_ctrl #(
    parameter int BATT_W       = 8,
    parameter int LOW_BATT     = 32,
    parameter int CLEAN_CYCLES = 1000,
    parameter int EVADE_CYCLES = 16,
    parameter int DRAIN_DIV    = 64,
    parameter int CHARGE_DIV   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              power_sw,
    input  logic              start,
    input  logic              obstacle,
    input  logic              docked,
    output logic [2:0]        state_o,
    output logic              drive_o,
    output logic              brush_o,
    output logic              turn_o,
    output logic [BATT_W-1:0] batt_o,
    output logic              low_batt_o,
    output logic              clean_done_o
);

    // state  | meaning
    // OFF    | unpowered, motors off
    // IDLE   | powered, waiting for start or dock
    // CLEAN  | driving with brush, job timer running
    // EVADE  | turning away from an obstacle, job timer paused
    // RETURN | driving back to the dock
    // CHARGE | on the dock, battery refilling
    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_CLEAN  = 3'd2;
    localparam logic [2:0] ST_EVADE  = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;
    localparam logic [2:0] ST_CHARGE = 3'd5;

    localparam int CT_W    = $clog2(CLEAN_CYCLES + 1);
    localparam int EV_W    = $clog2(EVADE_CYCLES + 1);
    localparam int DIV_MAX = (DRAIN_DIV > CHARGE_DIV) ? DRAIN_DIV : CHARGE_DIV;
    localparam int PS_W    = $clog2(DIV_MAX + 1);

    localparam logic [BATT_W-1:0] BATT_MAX  = '1;
    localparam logic [BATT_W-1:0] BATT_LOW  = BATT_W'(LOW_BATT);
    localparam logic [BATT_W-1:0] BATT_ONE  = BATT_W'(1);
    localparam logic [CT_W-1:0]   CT_LAST   = CT_W'(CLEAN_CYCLES - 1);
    localparam logic [CT_W-1:0]   CT_ONE    = CT_W'(1);
    localparam logic [EV_W-1:0]   EV_LOAD   = EV_W'(EVADE_CYCLES);
    localparam logic [EV_W-1:0]   EV_ONE    = EV_W'(1);
    localparam logic [PS_W-1:0]   PS_DRAIN  = PS_W'(DRAIN_DIV - 1);
    localparam logic [PS_W-1:0]   PS_CHARGE = PS_W'(CHARGE_DIV - 1);
    localparam logic [PS_W-1:0]   PS_ONE    = PS_W'(1);

    logic [2:0]        state_q, state_nx;
    logic [CT_W-1:0]   clean_tmr_q, clean_tmr_nx;
    logic [EV_W-1:0]   evade_cnt_q, evade_cnt_nx;
    logic [PS_W-1:0]   presc_q, presc_nx;
    logic [BATT_W-1:0] batt_q, batt_nx;
    logic              done_q, done_nx;
    logic              moving;

    always_comb begin
        state_nx     = state_q;
        clean_tmr_nx = clean_tmr_q;
        evade_cnt_nx = evade_cnt_q;
        done_nx      = 1'b0;
        if (!power_sw) begin
            state_nx = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: state_nx = ST_IDLE;
                ST_IDLE: begin
                    if (docked && batt_q != BATT_MAX) begin
                        state_nx = ST_CHARGE;
                    end else if (start && batt_q > BATT_LOW) begin
                        state_nx     = ST_CLEAN;
                        clean_tmr_nx = '0;
                    end
                end
                ST_CLEAN: begin
                    if (batt_q == '0) begin
                        state_nx = ST_IDLE;
                    end else if (batt_q <= BATT_LOW) begin
                        state_nx = ST_RETURN;
                    end else if (clean_tmr_q == CT_LAST) begin
                        state_nx = ST_RETURN;
                        done_nx  = 1'b1;
                    end else begin
                        // the cycle that sees the obstacle still counts as a cleaning cycle
                        clean_tmr_nx = clean_tmr_q + CT_ONE;
                        if (obstacle) begin
                            state_nx     = ST_EVADE;
                            evade_cnt_nx = EV_LOAD;
                        end
                    end
                end
                ST_EVADE: begin
                    if (batt_q == '0) begin
                        state_nx = ST_IDLE;
                    end else if (evade_cnt_q > EV_ONE) begin
                        evade_cnt_nx = evade_cnt_q - EV_ONE;
                    end else if (!obstacle) begin
                        state_nx = ST_CLEAN;
                    end else begin
                        evade_cnt_nx = EV_LOAD;
                    end
                end
                ST_RETURN: begin
                    if (docked) begin
                        state_nx = ST_CHARGE;
                    end else if (batt_q == '0) begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_CHARGE: begin
                    if (!docked || batt_q == BATT_MAX) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_OFF;
            endcase
        end
    end

    assign moving = (state_q == ST_CLEAN) || (state_q == ST_EVADE) || (state_q == ST_RETURN);

    always_comb begin
        presc_nx = presc_q;
        batt_nx  = batt_q;
        if (moving) begin
            if (presc_q >= PS_DRAIN) begin
                presc_nx = '0;
                if (batt_q != '0) begin
                    batt_nx = batt_q - BATT_ONE;
                end
            end else begin
                presc_nx = presc_q + PS_ONE;
            end
        end else if (state_q == ST_CHARGE) begin
            if (presc_q >= PS_CHARGE) begin
                presc_nx = '0;
                if (batt_q != BATT_MAX) begin
                    batt_nx = batt_q + BATT_ONE;
                end
            end else begin
                presc_nx = presc_q + PS_ONE;
            end
        end else begin
            presc_nx = '0;
        end
        if (state_nx != state_q) begin
            presc_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            clean_tmr_q <= '0;
            evade_cnt_q <= '0;
            presc_q     <= '0;
            batt_q      <= BATT_MAX;
            done_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_nx;
            clean_tmr_q <= clean_tmr_nx;
            evade_cnt_q <= evade_cnt_nx;
            presc_q     <= presc_nx;
            batt_q      <= batt_nx;
            done_q      <= done_nx;
        end else begin
            done_q      <= 1'b0;
        end
    end

    assign state_o      = state_q;
    assign drive_o      = (state_q == ST_CLEAN) || (state_q == ST_RETURN);
    assign brush_o      = (state_q == ST_CLEAN);
    assign turn_o       = (state_q == ST_EVADE);
    assign batt_o       = batt_q;
    assign low_batt_o   = (batt_q <= BATT_LOW);
    assign clean_done_o = done_q & ena;

endmodule

// File: tb/tb_aspiradora_ctrl.sv
// Directed bench for aspiradora_ctrl with small parameters (4-bit battery, 10-cycle job).
module tb_aspiradora_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       power_sw;
    logic       start;
    logic       obstacle;
    logic       docked;
    logic [2:0] state_o;
    logic       drive_o;
    logic       brush_o;
    logic       turn_o;
    logic [3:0] batt_o;
    logic       low_batt_o;
    logic       clean_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    aspiradora_ctrl #(
        .BATT_W(4), .LOW_BATT(3), .CLEAN_CYCLES(10),
        .EVADE_CYCLES(4), .DRAIN_DIV(4), .CHARGE_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .power_sw(power_sw),
        .start(start), .obstacle(obstacle), .docked(docked),
        .state_o(state_o), .drive_o(drive_o), .brush_o(brush_o), .turn_o(turn_o),
        .batt_o(batt_o), .low_batt_o(low_batt_o), .clean_done_o(clean_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; power_sw = 1'b0; start = 1'b0;
        obstacle = 1'b0; docked = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Powers up and starts a job: IDLE after one edge, CLEAN after the second.
    task automatic go_clean();
        power_sw = 1'b1; start = 1'b1;
        step(2);
        start = 1'b0;
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL go_clean state got=%0d exp=2", state_o); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; power_sw = 1'b0; start = 1'b0; obstacle = 1'b0; docked = 1'b0;
        step(2);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        n_checks++; if (batt_o !== 4'd15) begin n_fail++; $display("FAIL reset_batt got=%0d exp=15", batt_o); end
        n_checks++; if ({drive_o, brush_o, turn_o, clean_done_o, low_batt_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=00000", {drive_o, brush_o, turn_o, clean_done_o, low_batt_o});
        end
        rst_n = 1'b1;
        step(2);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL unpowered_off got=%0d exp=0", state_o); end
    endtask

    task automatic test_basic_job();
        do_reset();
        power_sw = 1'b1; start = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL basic_idle got=%0d exp=1", state_o); end
        step(1);
        start = 1'b0;
        n_checks++; if (state_o !== 3'd2 || drive_o !== 1'b1 || brush_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_clean state=%0d drive=%b brush=%b exp=2,1,1", state_o, drive_o, brush_o);
        end
        step(9);
        n_checks++; if (state_o !== 3'd2 || clean_done_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_still_clean state=%0d done=%b exp=2,0", state_o, clean_done_o);
        end
        step(1);
        n_checks++; if (state_o !== 3'd4 || clean_done_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_done state=%0d done=%b exp=4,1", state_o, clean_done_o);
        end
        n_checks++; if (batt_o !== 4'd13) begin n_fail++; $display("FAIL basic_batt got=%0d exp=13", batt_o); end
        n_checks++; if (drive_o !== 1'b1 || brush_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_return_motors drive=%b brush=%b exp=1,0", drive_o, brush_o);
        end
        step(1);
        n_checks++; if (clean_done_o !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", clean_done_o); end
    endtask

    task automatic test_charge();
        do_reset();
        go_clean();
        step(10);
        step(12);
        n_checks++; if (state_o !== 3'd4 || batt_o !== 4'd10) begin
            n_fail++; $display("FAIL charge_pre state=%0d batt=%0d exp=4,10", state_o, batt_o);
        end
        docked = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd5 || batt_o !== 4'd10) begin
            n_fail++; $display("FAIL charge_enter state=%0d batt=%0d exp=5,10", state_o, batt_o);
        end
        step(2);
        n_checks++; if (batt_o !== 4'd11) begin n_fail++; $display("FAIL charge_first_inc got=%0d exp=11", batt_o); end
        step(8);
        n_checks++; if (state_o !== 3'd5 || batt_o !== 4'd15) begin
            n_fail++; $display("FAIL charge_full state=%0d batt=%0d exp=5,15", state_o, batt_o);
        end
        step(1);
        n_checks++; if (state_o !== 3'd1 || batt_o !== 4'd15) begin
            n_fail++; $display("FAIL charge_exit state=%0d batt=%0d exp=1,15", state_o, batt_o);
        end
        step(1);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL charge_full_stays_idle got=%0d exp=1", state_o); end
        docked = 1'b0;
    endtask

    task automatic test_dock_drop();
        do_reset();
        go_clean();
        step(10);
        docked = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd5 || batt_o !== 4'd13) begin
            n_fail++; $display("FAIL drop_enter state=%0d batt=%0d exp=5,13", state_o, batt_o);
        end
        step(2);
        n_checks++; if (batt_o !== 4'd14) begin n_fail++; $display("FAIL drop_inc got=%0d exp=14", batt_o); end
        docked = 1'b0;
        step(1);
        n_checks++; if (state_o !== 3'd1 || batt_o !== 4'd14) begin
            n_fail++; $display("FAIL drop_idle state=%0d batt=%0d exp=1,14", state_o, batt_o);
        end
        docked = 1'b1; start = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd5) begin n_fail++; $display("FAIL dock_over_start got=%0d exp=5", state_o); end
        docked = 1'b0; start = 1'b0;
    endtask

    task automatic test_evade_single();
        do_reset();
        go_clean();
        step(5);
        obstacle = 1'b1;
        step(1);
        obstacle = 1'b0;
        n_checks++; if (state_o !== 3'd3 || turn_o !== 1'b1 || drive_o !== 1'b0 || brush_o !== 1'b0) begin
            n_fail++; $display("FAIL evade_enter state=%0d turn=%b drive=%b brush=%b exp=3,1,0,0", state_o, turn_o, drive_o, brush_o);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++; if (turn_o !== 1'b1) begin n_fail++; $display("FAIL evade_turn_%0d got=%b exp=1", i, turn_o); end
        end
        step(1);
        n_checks++; if (state_o !== 3'd2 || turn_o !== 1'b0) begin
            n_fail++; $display("FAIL evade_back state=%0d turn=%b exp=2,0", state_o, turn_o);
        end
        step(3);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL evade_late_clean got=%0d exp=2", state_o); end
        step(1);
        n_checks++; if (state_o !== 3'd4 || clean_done_o !== 1'b1 || batt_o !== 4'd12) begin
            n_fail++; $display("FAIL evade_done state=%0d done=%b batt=%0d exp=4,1,12", state_o, clean_done_o, batt_o);
        end
    endtask

    task automatic test_evade_hold();
        int turn_cnt;
        turn_cnt = 0;
        do_reset();
        go_clean();
        step(5);
        obstacle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (turn_o === 1'b1) turn_cnt++;
            if (i == 5) obstacle = 1'b0;
        end
        n_checks++; if (turn_cnt !== 8) begin n_fail++; $display("FAIL hold_turn_cycles got=%0d exp=8", turn_cnt); end
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL hold_back_clean got=%0d exp=2", state_o); end
    endtask

    task automatic test_start_obstacle();
        do_reset();
        power_sw = 1'b1;
        step(1);
        start = 1'b1; obstacle = 1'b1;
        step(1);
        start = 1'b0;
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL startobs_clean got=%0d exp=2", state_o); end
        step(1);
        obstacle = 1'b0;
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL startobs_evade got=%0d exp=3", state_o); end
    endtask

    task automatic test_low_batt();
        int done_seen;
        done_seen = 0;
        do_reset();
        go_clean();
        obstacle = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step(1);
            if (clean_done_o === 1'b1) done_seen++;
        end
        obstacle = 1'b0;
        n_checks++; if (state_o !== 3'd3 || batt_o !== 4'd4 || low_batt_o !== 1'b0) begin
            n_fail++; $display("FAIL low_pre state=%0d batt=%0d low=%b exp=3,4,0", state_o, batt_o, low_batt_o);
        end
        step(1);
        n_checks++; if (state_o !== 3'd2 || batt_o !== 4'd3 || low_batt_o !== 1'b1) begin
            n_fail++; $display("FAIL low_clean state=%0d batt=%0d low=%b exp=2,3,1", state_o, batt_o, low_batt_o);
        end
        step(1);
        if (clean_done_o === 1'b1) done_seen++;
        n_checks++; if (state_o !== 3'd4 || batt_o !== 4'd3) begin
            n_fail++; $display("FAIL low_return state=%0d batt=%0d exp=4,3", state_o, batt_o);
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL low_no_done got=%0d pulses exp=0", done_seen); end
        power_sw = 1'b0;
        step(1);
        n_checks++; if (state_o !== 3'd0 || batt_o !== 4'd3) begin
            n_fail++; $display("FAIL persist_off state=%0d batt=%0d exp=0,3", state_o, batt_o);
        end
        power_sw = 1'b1; start = 1'b1;
        step(2);
        n_checks++; if (state_o !== 3'd1 || batt_o !== 4'd3) begin
            n_fail++; $display("FAIL low_start_refused state=%0d batt=%0d exp=1,3", state_o, batt_o);
        end
        start = 1'b0;
    endtask

    task automatic test_power_off_evade();
        do_reset();
        go_clean();
        obstacle = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL pwroff_evade got=%0d exp=3", state_o); end
        power_sw = 1'b0;
        step(1);
        obstacle = 1'b0;
        n_checks++; if (state_o !== 3'd0 || turn_o !== 1'b0) begin
            n_fail++; $display("FAIL pwroff_off state=%0d turn=%b exp=0,0", state_o, turn_o);
        end
    endtask

    task automatic test_ena_freeze();
        do_reset();
        go_clean();
        step(9);
        ena = 1'b0;
        step(5);
        n_checks++; if (state_o !== 3'd2 || batt_o !== 4'd13 || clean_done_o !== 1'b0) begin
            n_fail++; $display("FAIL freeze_hold state=%0d batt=%0d done=%b exp=2,13,0", state_o, batt_o, clean_done_o);
        end
        ena = 1'b1;
        step(1);
        n_checks++; if (state_o !== 3'd4 || clean_done_o !== 1'b1 || batt_o !== 4'd13) begin
            n_fail++; $display("FAIL freeze_resume state=%0d done=%b batt=%0d exp=4,1,13", state_o, clean_done_o, batt_o);
        end
        ena = 1'b0;
        #1;
        n_checks++; if (clean_done_o !== 1'b0) begin n_fail++; $display("FAIL freeze_done_masked got=%b exp=0", clean_done_o); end
        step(1);
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL freeze_state_held got=%0d exp=4", state_o); end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid_clean();
        int done_seen;
        done_seen = 0;
        do_reset();
        go_clean();
        step(5);
        n_checks++; if (batt_o !== 4'd14) begin n_fail++; $display("FAIL midrst_pre_batt got=%0d exp=14", batt_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state_o !== 3'd0 || batt_o !== 4'd15 || drive_o !== 1'b0 || brush_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async state=%0d batt=%0d drive=%b brush=%b exp=0,15,0,0", state_o, batt_o, drive_o, brush_o);
        end
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (clean_done_o === 1'b1) done_seen++;
        end
        n_checks++; if (done_seen !== 0 || state_o !== 3'd1) begin
            n_fail++; $display("FAIL midrst_abandon pulses=%0d state=%0d exp=0,1", done_seen, state_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_charge();
        test_dock_drop();
        test_evade_single();
        test_evade_hold();
        test_start_obstacle();
        test_low_batt();
        test_power_off_evade();
        test_ena_freeze();
        test_reset_mid_clean();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
